frame_pixel_packer: RTL and testbench
=====================================

// Module: frame_pixel_packer
// PURPOSE
//  Write-side front end of the frame buffer that the image processor reads.
//  It takes the camera's 8-bit pixel stream and packs each run of 16 pixels into one 128-bit word.
//  Packed words go to the frame BRAM at 13-bit word addresses.
//  It publishes the frame slot (currentFrame) that the processor consumes.
// PARAMETERS
//  PIX_W           8     bits per pixel
//  PIX_PER_WORD    16    pixels per packed word (word width = PIX_W*PIX_PER_WORD = 128)
//  WORDS_PER_FRAME 4800  words per frame (320x240/16)
//  NUM_FRAMES      8     frame slots in ring; currentFrame wraps modulo NUM_FRAMES
// PORTS
//  clk           in   1    system clock, all logic rising-edge
//  rst_n         in   1    asynchronous active-low reset
//  capture_en    in   1    1 = accept new frames; sampled only in IDLE
//  frame_start   in   1    1-cycle pulse, start of camera frame (vsync edge)
//  pix_valid     in   1    pix_data valid this cycle
//  pix_data      in   8    pixel value
//  writeAddress  out  13   word address within current slot
//  writePixel    out  128  packed word; first pixel of group in [127:120], 16th in [7:0]
//  writeEn       out  1    1-cycle write strobe for writeAddress/writePixel
//  currentFrame  out  3    slot being filled
//  frameDone     out  1    1-cycle pulse, last word of a complete frame written
//  doneFrame     out  3    slot index that frameDone refers to, valid with frameDone
//  dropCnt       out  16   pixels discarded (overlong frame or outside CAPTURE), saturating
//  shortCnt      out  16   frames aborted by early frame_start, saturating
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE.
//   Outputs writeAddress, writePixel, writeEn, currentFrame, frameDone, doneFrame, dropCnt and shortCnt all = 0.
//   Lane counter and shift register are cleared.
//  States: IDLE, CAPTURE, FLUSH.
//  IDLE:
//   - frame_start && capture_en -> CAPTURE, with word addr=0 and lane=0.
//   - pix_valid in IDLE increments dropCnt.
//  CAPTURE:
//   - Each pix_valid shifts pix_data into the word MSB-first and increments lane 0..15.
//   - On the 16th pixel (lane=15), writePixel/writeAddress are registered and writeEn=1 on the next cycle.
//     Latency: 1 cycle from the 16th pixel_valid edge to the writeEn edge.
//   - After a write, the address increments.
//   - The write of address WORDS_PER_FRAME-1 -> FLUSH.
//  FLUSH (1 cycle):
//   - frameDone=1 and doneFrame=currentFrame.
//   - currentFrame <= (currentFrame+1) mod NUM_FRAMES.
//   - Then -> CAPTURE if frame_start seen this cycle and capture_en, else IDLE.
//  Overlong frame: pixels arriving after the last word (FLUSH/IDLE) are dropped and counted in dropCnt.
//  Short frame: frame_start in CAPTURE before the last word ->
//   - shortCnt++.
//   - Partial word discarded, no write.
//   - addr=0, lane=0, same currentFrame reused.
//   - Stays in CAPTURE if capture_en, else IDLE.
//   - frameDone is not pulsed.
//  Simultaneous frame_start and pix_valid in any state: frame_start takes effect first.
//   That pixel is the first pixel (lane 0) of the new frame.
//  Simultaneous 16th pixel and frame_start: the frame_start rule applies; the word is not written.
//  capture_en deassert mid-frame: the current frame completes; no new frame starts.
//  Counters saturate at 16'hFFFF, no wrap.
//  writeAddress and writePixel hold their last values while writeEn=0.
//  Reset mid-frame discards everything, with no write or frameDone.
// STRUCTURE
//  Shared package (fb_pkg): PIX_W, PIX_PER_WORD, WORDS_PER_FRAME, NUM_FRAMES, ADDR_W=13, SLOT_W=3.
//   The same package is used by imgproc_scheduled.
//  One sub-module: pix_shift_packer (shift register + lane counter, emits word_valid).
//  FSM, address, slot and counters live in the top.
// TESTING
//  1. Reset, then frame_start, then 16 pixels 0x00..0x0F ->
//     writeEn one cycle later, writeAddress=0, writePixel=128'h000102030405060708090a0b0c0d0e0f.
//  2. Full frame of 76800 pixels -> 4800 writeEn pulses with addr 0..4799 and one frameDone with doneFrame=0.
//     currentFrame=1 afterwards.
//  3. Eight full frames -> doneFrame 0..7, then currentFrame wraps to 0.
//  4. frame_start after 100 pixels -> shortCnt=1, 6 writes only (the 4-pixel partial word is dropped).
//     Next frame starts at addr 0 with currentFrame unchanged.
//  5. 76810 pixels in one frame -> frameDone once, dropCnt=10.
//     10 pixels with capture_en=0 in IDLE -> dropCnt=20.
//  6. rst_n low mid-word (lane 7) -> all outputs 0 immediately.
//     After release, the next frame's first word equals fresh pixels only.

Source files
------------

// File: rtl/fb_pkg.sv
// Frame buffer shared definitions: pixel/word geometry,
// slot ring size, FSM state type and a saturating counter helper.
package fb_pkg;

    localparam int PIX_W           = 8;
    localparam int PIX_PER_WORD    = 16;
    localparam int WORD_W          = PIX_W * PIX_PER_WORD;
    localparam int WORDS_PER_FRAME = 4800;
    localparam int NUM_FRAMES      = 8;
    localparam int ADDR_W          = 13;
    localparam int SLOT_W          = 3;
    localparam int LANE_W          = 4;
    localparam int CNT_W           = 16;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        FLUSH
    } fbState_e;

    function automatic logic [CNT_W-1:0] satInc(
        input logic [CNT_W-1:0] c
    );
        return (&c) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/pix_shift_packer.sv
// Shifts pixels MSB-first into a 16-lane word; wordValid flags the 16th pixel.
// Ports: clk, rst_n, restart, shiftEn, pixIn -> wordOut, wordValid.
module pix_shift_packer
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic              shiftEn,
    input  logic [PIX_W-1:0]  pixIn,
    output logic [WORD_W-1:0] wordOut,
    output logic              wordValid
);

    logic [WORD_W-1:0] shiftReg;
    logic [LANE_W-1:0] lane;

    assign wordOut   = {shiftReg[WORD_W-PIX_W-1:0], pixIn};
    assign wordValid = shiftEn && !restart &&
                       (lane == LANE_W'(PIX_PER_WORD - 1));

    // restart drops the partial word; a pixel arriving with it
    // becomes lane 0 of the fresh word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shiftReg <= '0;
            lane     <= '0;
        end else if (restart) begin
            lane     <= {{(LANE_W-1){1'b0}}, shiftEn};
            shiftReg <= shiftEn ? {{(WORD_W-PIX_W){1'b0}}, pixIn} : '0;
        end else if (shiftEn) begin
            lane     <= lane + 1'b1;
            shiftReg <= wordOut;
        end
    end

endmodule

// File: rtl/frame_pixel_packer.sv
// Packs the camera pixel stream into 128-bit frame BRAM words and rotates
// the frame slot ring. Ports: pixel/frame inputs, BRAM write port, slot and
// completion status, saturating drop/short-frame counters.
module frame_pixel_packer
    import fb_pkg::*;
#(
    parameter int FRAME_WORDS = WORDS_PER_FRAME
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture_en,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    output logic [ADDR_W-1:0] writeAddress,
    output logic [WORD_W-1:0] writePixel,
    output logic              writeEn,
    output logic [SLOT_W-1:0] currentFrame,
    output logic              frameDone,
    output logic [SLOT_W-1:0] doneFrame,
    output logic [CNT_W-1:0]  dropCnt,
    output logic [CNT_W-1:0]  shortCnt
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

    fbState_e          state;
    fbState_e          nextState;
    fbState_e          stateNext;
    logic              restart;
    logic              shiftEn;
    logic              doDrop;
    logic              doShort;
    logic              bumpSlot;
    logic              startOk;
    logic              wordValid;
    logic              atLast;
    logic [WORD_W-1:0] wordOut;
    logic [ADDR_W-1:0] wordAddr;

    pix_shift_packer uPacker (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart   (restart),
        .shiftEn   (shiftEn),
        .pixIn     (pix_data),
        .wordOut   (wordOut),
        .wordValid (wordValid)
    );

    assign startOk   = frame_start && capture_en;
    assign atLast    = (wordAddr == LAST_ADDR);
    // Kept out of the FSM block: wordValid depends on shiftEn.
    assign stateNext = (wordValid && atLast) ? FLUSH : nextState;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        nextState = state;
        restart   = 1'b0;
        shiftEn   = 1'b0;
        doDrop    = 1'b0;
        doShort   = 1'b0;
        bumpSlot  = 1'b0;
        unique case (state)
            IDLE: begin
                if (startOk) begin
                    nextState = CAPTURE;
                    restart   = 1'b1;
                    shiftEn   = pix_valid;
                end else begin
                    doDrop    = pix_valid;
                end
            end
            CAPTURE: begin
                if (frame_start) begin
                    doShort = 1'b1;
                    restart = 1'b1;
                    if (capture_en) begin
                        shiftEn   = pix_valid;
                    end else begin
                        nextState = IDLE;
                        doDrop    = pix_valid;
                    end
                end else begin
                    shiftEn = pix_valid;
                end
            end
            FLUSH: begin
                bumpSlot = 1'b1;
                if (startOk) begin
                    nextState = CAPTURE;
                    restart   = 1'b1;
                    shiftEn   = pix_valid;
                end else begin
                    nextState = IDLE;
                    doDrop    = pix_valid;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wordAddr     <= '0;
            writeAddress <= '0;
            writePixel   <= '0;
            writeEn      <= 1'b0;
            currentFrame <= '0;
            frameDone    <= 1'b0;
            doneFrame    <= '0;
            dropCnt      <= '0;
            shortCnt     <= '0;
        end else begin
            writeEn   <= wordValid;
            frameDone <= wordValid && atLast;
            if (restart)        wordAddr <= '0;
            else if (wordValid) wordAddr <= wordAddr + 1'b1;
            if (wordValid) begin
                writeAddress <= wordAddr;
                writePixel   <= wordOut;
            end
            if (wordValid && atLast) doneFrame <= currentFrame;
            // Ring of 8 slots: natural 3-bit wrap.
            if (bumpSlot) currentFrame <= currentFrame + 1'b1;
            if (doDrop)   dropCnt      <= satInc(dropCnt);
            if (doShort)  shortCnt     <= satInc(shortCnt);
        end
    end

endmodule

// File: tb/tb_frame_pixel_packer.sv
// Directed bench for frame_pixel_packer on a reduced 10-word frame:
// packing, slot ring, short/overlong frames, drops and async reset.
module tb_frame_pixel_packer;
    import fb_pkg::*;

    localparam int WPF = 10;
    localparam int PPF = WPF * PIX_PER_WORD;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              capture_en = 1'b0;
    logic              frame_start = 1'b0;
    logic              pix_valid = 1'b0;
    logic [PIX_W-1:0]  pix_data = '0;
    logic [ADDR_W-1:0] writeAddress;
    logic [WORD_W-1:0] writePixel;
    logic              writeEn;
    logic [SLOT_W-1:0] currentFrame;
    logic              frameDone;
    logic [SLOT_W-1:0] doneFrame;
    logic [CNT_W-1:0]  dropCnt;
    logic [CNT_W-1:0]  shortCnt;

    always #5 clk = ~clk;

    frame_pixel_packer #(.FRAME_WORDS(WPF)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .capture_en   (capture_en),
        .frame_start  (frame_start),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .writeAddress (writeAddress),
        .writePixel   (writePixel),
        .writeEn      (writeEn),
        .currentFrame (currentFrame),
        .frameDone    (frameDone),
        .doneFrame    (doneFrame),
        .dropCnt      (dropCnt),
        .shortCnt     (shortCnt)
    );

    int nCmp = 0;
    int nMis = 0;

    logic [ADDR_W-1:0] addrQ[$];
    logic [WORD_W-1:0] dataQ[$];
    logic [SLOT_W-1:0] doneQ[$];

    always @(negedge clk) begin
        if (writeEn) begin
            addrQ.push_back(writeAddress);
            dataQ.push_back(writePixel);
        end
        if (frameDone) doneQ.push_back(doneFrame);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
        nCmp++;
        if (obs !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WORD_W-1:0] expWord(input logic [7:0] b0);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int j = 0; j < PIX_PER_WORD; j++)
            w[WORD_W-1-8*j -: 8] = b0 + 8'(j);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pixLoop(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            pix_valid = 1'b1;
            pix_data  = base + 8'(i);
            tick();
        end
        pix_valid = 1'b0;
    endtask

    task automatic startFrame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // frame_start arrives together with the first pixel
    task automatic runFrame(input int n, input logic [7:0] base);
        frame_start = 1'b1;
        pix_valid   = 1'b1;
        pix_data    = base;
        tick();
        frame_start = 1'b0;
        pixLoop(n - 1, base + 8'd1);
    endtask

    task automatic checkWrites(input string tag, input int n,
                               input logic [7:0] base);
        chk({tag, ".nwr"}, 128'(addrQ.size()), 128'(n));
        for (int k = 0; k < n && k < addrQ.size(); k++) begin
            chk({tag, ".addr"}, 128'(addrQ[k]), 128'(k));
            chk({tag, ".data"}, dataQ[k], expWord(base + 8'(16 * k)));
        end
        addrQ.delete();
        dataQ.delete();
    endtask

    task automatic checkDone(input string tag, input int n,
                             input logic [2:0] first);
        chk({tag, ".ndone"}, 128'(doneQ.size()), 128'(n));
        for (int k = 0; k < n && k < doneQ.size(); k++)
            chk({tag, ".slot"}, 128'(doneQ[k]), 128'(first + 3'(k)));
        doneQ.delete();
    endtask

    task automatic checkZero(input string tag);
        chk({tag, ".addr"}, 128'(writeAddress), 128'(0));
        chk({tag, ".pix"}, writePixel, 128'(0));
        chk({tag, ".we"}, 128'(writeEn), 128'(0));
        chk({tag, ".cur"}, 128'(currentFrame), 128'(0));
        chk({tag, ".done"}, 128'(frameDone), 128'(0));
        chk({tag, ".dslot"}, 128'(doneFrame), 128'(0));
        chk({tag, ".drop"}, 128'(dropCnt), 128'(0));
        chk({tag, ".short"}, 128'(shortCnt), 128'(0));
    endtask

    initial begin
        capture_en = 1'b1;
        #1;
        checkZero("rst");
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;

        // first word latency and content
        startFrame();
        pixLoop(15, 8'h00);
        chk("lat.we0", 128'(writeEn), 128'(0));
        pixLoop(1, 8'h0f);
        chk("lat.we1", 128'(writeEn), 128'(1));
        chk("lat.addr", 128'(writeAddress), 128'(0));
        chk("lat.pix", writePixel,
            128'h000102030405060708090a0b0c0d0e0f);

        // rest of frame 0
        pixLoop(PPF - 16, 8'h10);
        chk("f0.done", 128'(frameDone), 128'(1));
        chk("f0.dslot", 128'(doneFrame), 128'(0));
        tick();
        chk("f0.cur", 128'(currentFrame), 128'(1));
        chk("f0.hold.we", 128'(writeEn), 128'(0));
        chk("f0.hold.addr", 128'(writeAddress), 128'(WPF - 1));
        chk("f0.hold.pix", writePixel, expWord(8'(16 * (WPF - 1))));
        checkWrites("f0", WPF, 8'h00);
        checkDone("f0", 1, 3'd0);

        // seven more frames, back-to-back through FLUSH
        for (int f = 1; f < 8; f++) begin
            runFrame(PPF, 8'h00);
            #5;
            checkWrites("ring", WPF, 8'h00);
        end
        tick();
        checkDone("ring", 7, 3'd1);
        chk("ring.wrap", 128'(currentFrame), 128'(0));

        // short frame
        runFrame(100, 8'h00);
        startFrame();
        chk("short.cnt", 128'(shortCnt), 128'(1));
        chk("short.cur", 128'(currentFrame), 128'(0));
        checkWrites("short", 6, 8'h00);
        checkDone("short", 0, 3'd0);
        pixLoop(PPF, 8'h00);
        tick();
        checkWrites("afterShort", WPF, 8'h00);
        checkDone("afterShort", 1, 3'd0);
        chk("afterShort.cur", 128'(currentFrame), 128'(1));

        // overlong frame and idle drops
        runFrame(PPF + 10, 8'h00);
        chk("long.drop", 128'(dropCnt), 128'(10));
        chk("long.cur", 128'(currentFrame), 128'(2));
        checkWrites("long", WPF, 8'h00);
        checkDone("long", 1, 3'd1);
        capture_en = 1'b0;
        pixLoop(10, 8'h00);
        chk("idle.drop", 128'(dropCnt), 128'(20));
        startFrame();
        pixLoop(16, 8'h00);
        tick();
        chk("noCap.nwr", 128'(addrQ.size()), 128'(0));
        chk("noCap.drop", 128'(dropCnt), 128'(36));
        chk("noCap.short", 128'(shortCnt), 128'(1));

        // async reset mid-word
        capture_en = 1'b1;
        startFrame();
        pixLoop(23, 8'h00);
        #3;
        rst_n = 1'b0;
        #1;
        checkZero("midRst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        addrQ.delete();
        dataQ.delete();
        doneQ.delete();
        startFrame();
        pixLoop(16, 8'h80);
        chk("fresh.we", 128'(writeEn), 128'(1));
        chk("fresh.addr", 128'(writeAddress), 128'(0));
        chk("fresh.pix", writePixel, expWord(8'h80));

        // capture_en drops mid-frame: frame completes, no new one
        capture_en = 1'b0;
        pixLoop(PPF - 16, 8'h90);
        tick();
        checkWrites("ceOff", WPF, 8'h80);
        checkDone("ceOff", 1, 3'd0);
        chk("ceOff.cur", 128'(currentFrame), 128'(1));
        startFrame();
        pixLoop(16, 8'h00);
        tick();
        chk("ceOff.nwr", 128'(addrQ.size()), 128'(0));
        chk("ceOff.drop", 128'(dropCnt), 128'(16));
        chk("ceOff.short", 128'(shortCnt), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nCmp, nMis);
        $finish;
    end

endmodule
